pwm_color_wheel: RTL and testbench
==================================

Name: pwm_color_wheel

Overview:
Parametrised N-channel PWM colour-wheel generator, successor to the fixed three-instance RGB fader. A single shared wheel position drives every channel; each channel reads it at its own phase offset. Adds a run/freeze enable, a direction control, glitch-free duty updates, a selectable output polarity and a wheel-wrap pulse. Sits between the clock and the board LED pins; no external configuration bus.

Parameters:
N_CH, 3, number of output channels.
PWM_BITS, 8, PWM resolution B; S = 2^B clocks per PWM period; duty range 0..S.
STEP_CLKS, 15625, clocks per wheel step (prescaler period, >=1); full wheel of 1536 steps is about 2 s at 12 MHz.
CH_OFFSET, 2*2^PWM_BITS, wheel-position offset between adjacent channels (steps).
ACTIVE_LOW, 1, 1 = outputs inverted for common-anode LEDs; 0 = active-high.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
en  in  1  1 = wheel advances; 0 = wheel position and prescaler frozen, PWM keeps running.
dir  in  1  0 = forward (position increments), 1 = reverse (position decrements).
led_out  out  N_CH  per-channel PWM drive, registered, polarity set by ACTIVE_LOW.
wrap_pulse  out  1  one-cycle pulse when the wheel position wraps.

Behaviour:
- Wheel constants: S = 2^B; PERIOD = 6*S steps. Position register pos is 0..PERIOD-1.
- Prescaler psc counts 0..STEP_CLKS-1 only while en=1 and holds while en=0. tick = en & (psc==STEP_CLKS-1); on tick psc returns to 0.
- On tick with dir=0: pos <= (pos==PERIOD-1) ? 0 : pos+1. On tick with dir=1: pos <= (pos==0) ? PERIOD-1 : pos-1. A change of dir takes effect on the next tick.
- wrap_pulse is registered: high for exactly one cycle, the cycle after a tick that wraps pos (PERIOD-1->0 forward, 0->PERIOD-1 reverse). Otherwise 0.
- Channel position: p_c = (pos + c*CH_OFFSET) mod PERIOD. Compute the sum at adequate width, then apply a single conditional subtract; CH_OFFSET*(N_CH-1) < 2*PERIOD is required.
- Channel state (combinational from p_c):
  - RAMP_UP: p < S, target duty p.
  - HOLD_HI: S <= p < 3S, target duty S.
  - RAMP_DN: 3S <= p < 4S, target duty 4S-p.
  - HOLD_LO: 4S <= p < 6S, target duty 0.
  - Duty width is B+1.
- PWM counter pwm_cnt is B bits, free-running 0..S-1, and wraps every S clocks regardless of en.
- Glitch-free update: duty_q[c] loads its target only in the cycle where pwm_cnt==S-1, so a new duty starts exactly at pwm_cnt==0. Mid-period target changes are never visible.
- led_out[c] register <= (pwm_cnt < duty_q[c]) XOR ACTIVE_LOW, giving one cycle of latency from pwm_cnt. duty 0 = constant off; duty S = constant on.
- Reset (synchronous, overrides everything; may arrive mid-operation):
  - pos, psc, pwm_cnt and all duty_q are cleared to 0.
  - wrap_pulse is 0.
  - led_out = {N_CH{ACTIVE_LOW}}, i.e. all LEDs off.
  - First PWM period after reset uses duty 0; new targets load at the first pwm_cnt==S-1.
- Simultaneous reset and tick: reset wins, no wrap_pulse.
- en falling during a step: psc holds its value and resumes from it when en rises; no partial step is lost or doubled.

Test Plan:
(All with B=2, STEP_CLKS=2, N_CH=3, CH_OFFSET=8, ACTIVE_LOW=0; S=4, PERIOD=24.)
1. Reset and freeze: hold reset 3 cycles, then en=0 -> led_out=000 and wrap_pulse=0 throughout; pos stays 0; ch1 (p=8, HOLD_HI) reads constant 1 after its first duty load and ch2 (p=16, HOLD_LO) stays 0.
2. Ramp duty and update timing: run until pos=2, then set en=0 -> ch0 high exactly 2 of every 4 clocks, aligned to pwm_cnt 0..1. At pos=3 the pattern is 3 of 4; the new duty first appears at pwm_cnt==0 and never mid-period.
3. Forward wrap: en=1, dir=0 from reset -> wrap_pulse high for exactly 1 cycle after 24 ticks (48 clocks + 1 register cycle); pos=0 afterwards.
4. Reverse wrap: from reset, dir=1, en=1 -> after the first tick pos=23 and wrap_pulse pulses once; ch0 at p=23 (HOLD_LO) reads 0 and ch1 at p=7 (HOLD_HI) reads 1.
5. Mid-operation events:
   - Toggle en low for 5 cycles mid-step -> tick spacing resumes with no lost or double step.
   - Assert reset at pos=13 -> within 1 cycle led_out=000 and pos=0.
6. Polarity: rerun scenario 1 with ACTIVE_LOW=1 -> led_out=111 during reset; ch1 in HOLD_HI reads constant 0.

Source files
------------

// File: rtl/pwm_color_wheel.sv
// N-channel PWM colour wheel: one shared wheel position, read by each channel
// at its own phase offset, drives a trapezoidal duty profile per LED.
// Duty changes take effect only at PWM period boundaries, so a period is never
// shortened or stretched by a mid-period wheel step.
module pwm_color_wheel #(
    parameter int N_CH       = 3,
    parameter int PWM_BITS   = 8,
    parameter int STEP_CLKS  = 15625,
    parameter int CH_OFFSET  = 2 * (2 ** PWM_BITS),
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            dir,
    output logic [N_CH-1:0] led_out,
    output logic            wrap_pulse
);

    localparam int S      = 2 ** PWM_BITS;
    localparam int PERIOD = 6 * S;
    localparam int POS_W  = $clog2(PERIOD);
    localparam int SUM_W  = POS_W + 1;
    localparam int PSC_W  = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

    localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(PERIOD - 1);
    localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(STEP_CLKS - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;
    localparam logic [POS_W-1:0]    P_S       = POS_W'(S);
    localparam logic [POS_W-1:0]    P_3S      = POS_W'(3 * S);
    localparam logic [POS_W-1:0]    P_4S      = POS_W'(4 * S);
    localparam logic [PWM_BITS:0]   DUTY_FULL = (PWM_BITS + 1)'(S);
    localparam logic [SUM_W-1:0]    SUM_PER   = SUM_W'(PERIOD);

    // Channel offsets are reduced modulo the wheel length at elaboration, so
    // the runtime sum stays below 2*PERIOD and one conditional subtract suffices.
    function automatic logic [SUM_W-1:0] chan_offset(input int c);
        return SUM_W'((c * CH_OFFSET) % PERIOD);
    endfunction

    // Trapezoid profile: ramp up, hold high, ramp down, hold low.
    function automatic logic [PWM_BITS:0] target_duty(input logic [POS_W-1:0] p);
        if (p < P_S)
            return p[PWM_BITS:0];
        else if (p < P_3S)
            return DUTY_FULL;
        else if (p < P_4S)
            return (PWM_BITS + 1)'(P_4S - p);
        else
            return '0;
    endfunction

    logic [PSC_W-1:0]    psc;
    logic [POS_W-1:0]    pos;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS:0]   duty_q   [N_CH];
    logic [PWM_BITS:0]   target   [N_CH];
    logic [SUM_W-1:0]    chan_sum [N_CH];
    logic                tick;
    logic                wrap_now;

    assign tick     = en && (psc == PSC_LAST);
    assign wrap_now = dir ? (pos == '0) : (pos == POS_LAST);

    // Prescaler, wheel position and registered wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc        <= '0;
            pos        <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= tick && wrap_now;
            if (en)
                psc <= tick ? '0 : psc + PSC_W'(1);
            if (tick) begin
                if (dir)
                    pos <= wrap_now ? POS_LAST : pos - POS_W'(1);
                else
                    pos <= wrap_now ? '0 : pos + POS_W'(1);
            end
        end
    end

    // Per-channel wheel position and target duty.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            chan_sum[c] = {1'b0, pos} + chan_offset(c);
            if (chan_sum[c] >= SUM_PER)
                chan_sum[c] = chan_sum[c] - SUM_PER;
            target[c] = target_duty(chan_sum[c][POS_W-1:0]);
        end
    end

    // PWM counter, period-aligned duty load and registered LED drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            led_out <= {N_CH{ACTIVE_LOW}};
            for (int c = 0; c < N_CH; c++)
                duty_q[c] <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int c = 0; c < N_CH; c++) begin
                if (pwm_cnt == CNT_LAST)
                    duty_q[c] <= target[c];
                led_out[c] <= ({1'b0, pwm_cnt} < duty_q[c]) ^ ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_pwm_color_wheel.sv
// Bench for pwm_color_wheel with B=2, STEP_CLKS=2, N_CH=3, CH_OFFSET=8.
// Two instances share stimulus: one active-high, one active-low.
module tb_pwm_color_wheel;

    localparam int S   = 4;
    localparam int PER = 24;
    localparam int SC  = 2;
    localparam int OFF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] led_hi, led_lo;
    logic       wrap_hi, wrap_lo;

    always #5 clk = ~clk;

    pwm_color_wheel #(.N_CH(3), .PWM_BITS(2), .STEP_CLKS(2), .CH_OFFSET(8), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .led_out(led_hi), .wrap_pulse(wrap_hi));

    pwm_color_wheel #(.N_CH(3), .PWM_BITS(2), .STEP_CLKS(2), .CH_OFFSET(8), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .led_out(led_lo), .wrap_pulse(wrap_lo));

    typedef struct packed {
        logic [2:0] led;
        logic       wrap;
    } exp_t;

    typedef struct {
        int   steps;
        logic rev;
        int   d0, d1, d2;
        int   wraps;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_pos, m_psc, m_cnt;
    int m_duty[3];

    // observation bookkeeping
    int edge_no, wrap_cnt, wrap_edge;
    int hi_cnt[3];

    function automatic int ref_duty(input int p);
        case (p / S)
            0:       return p;
            1, 2:    return S;
            3:       return 4 * S - p;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int req);
        n_cmp++;
        if (act !== 32'(req)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_edge();
        exp_t e;
        bit   tk;
        if (reset) begin
            m_pos = 0; m_psc = 0; m_cnt = 0;
            for (int c = 0; c < 3; c++) m_duty[c] = 0;
            e.led  = 3'b000;
            e.wrap = 1'b0;
        end else begin
            tk = en && (m_psc == SC - 1);
            for (int c = 0; c < 3; c++) e.led[c] = (m_cnt < m_duty[c]);
            e.wrap = tk && (dir ? (m_pos == 0) : (m_pos == PER - 1));
            if (m_cnt == S - 1)
                for (int c = 0; c < 3; c++) m_duty[c] = ref_duty((m_pos + c * OFF) % PER);
            m_cnt = (m_cnt + 1) % S;
            if (tk) begin
                m_pos = dir ? (m_pos + PER - 1) % PER : (m_pos + 1) % PER;
                m_psc = 0;
            end else if (en) begin
                m_psc = m_psc + 1;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        edge_no++;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("led", led_hi, int'(e.led));
            check("led_al", led_lo, int'(e.led ^ 3'b111));
            check("wrap", wrap_hi, int'(e.wrap));
            check("wrap_al", wrap_lo, int'(e.wrap));
        end
        if (wrap_hi === 1'b1) begin
            wrap_cnt++;
            wrap_edge = edge_no;
        end
        for (int c = 0; c < 3; c++) hi_cnt[c] += int'(led_hi[c]);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; en = 1'b0; dir = 1'b0;
        repeat (n) step();
        reset = 1'b0;
        edge_no = 0; wrap_cnt = 0; wrap_edge = -1;
    endtask

    vec_t tbl[8];

    initial begin
        // steps, reverse, duty ch0/ch1/ch2, wraps seen while stepping
        tbl[0] = '{0,  1'b0, 0, 4, 0, 0};
        tbl[1] = '{2,  1'b0, 2, 4, 0, 0};
        tbl[2] = '{3,  1'b0, 3, 4, 0, 0};
        tbl[3] = '{5,  1'b0, 4, 3, 0, 0};
        tbl[4] = '{9,  1'b0, 4, 0, 1, 0};
        tbl[5] = '{14, 1'b0, 2, 0, 4, 0};
        tbl[6] = '{1,  1'b1, 0, 4, 1, 1};
        tbl[7] = '{6,  1'b1, 0, 2, 4, 1};

        edge_no = 0; wrap_cnt = 0; wrap_edge = -1;

        // Frozen-wheel duty patterns at a set of wheel positions.
        for (int i = 0; i < 8; i++) begin
            do_reset(3);
            en = 1'b1; dir = tbl[i].rev;
            repeat (2 * tbl[i].steps) step();
            check("vec_wraps", wrap_cnt, tbl[i].wraps);
            en = 1'b0;
            repeat (8) step();
            for (int c = 0; c < 3; c++) hi_cnt[c] = 0;
            repeat (4) step();
            check("vec_duty0", hi_cnt[0], tbl[i].d0);
            check("vec_duty1", hi_cnt[1], tbl[i].d1);
            check("vec_duty2", hi_cnt[2], tbl[i].d2);
        end

        // Forward wrap after 24 ticks.
        do_reset(3);
        en = 1'b1; dir = 1'b0;
        repeat (60) step();
        check("fwd_wrap_count", wrap_cnt, 1);
        check("fwd_wrap_edge", wrap_edge, 48);

        // Reverse: first tick wraps 0 -> 23, next wrap 24 ticks later.
        do_reset(3);
        en = 1'b1; dir = 1'b1;
        repeat (2) step();
        check("rev_first_wrap", wrap_hi, 1);
        repeat (50) step();
        check("rev_wrap_count", wrap_cnt, 2);
        check("rev_wrap_edge", wrap_edge, 50);

        // en dropped for 5 cycles mid-step: wrap shifts by exactly 5 clocks.
        do_reset(3);
        en = 1'b1; dir = 1'b0;
        repeat (3) step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (50) step();
        check("freeze_wrap_count", wrap_cnt, 1);
        check("freeze_wrap_edge", wrap_edge, 53);

        // Reset mid-operation at pos=13, then a clean restart.
        do_reset(3);
        en = 1'b1;
        repeat (26) step();
        reset = 1'b1;
        step();
        check("midrst_led", led_hi, 0);
        check("midrst_led_al", led_lo, 7);
        reset = 1'b0;
        edge_no = 0; wrap_cnt = 0; wrap_edge = -1;
        repeat (50) step();
        check("midrst_wrap_edge", wrap_edge, 48);

        // Reset coinciding with a wrapping tick suppresses the pulse.
        do_reset(3);
        en = 1'b1;
        repeat (47) step();
        reset = 1'b1;
        step();
        check("rst_tick_wrap", wrap_hi, 0);
        reset = 1'b0;
        repeat (3) step();
        check("rst_tick_wrap_count", wrap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
